// File: rtl/axi_pkg.sv
// Shared AXI read-channel types and helpers for the memory read slave.
// Holds the AR descriptor layout, burst/response encodings and beat-address math.
package axi_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2
    } axi_burst_t;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'd0,
        RESP_EXOKAY = 2'd1,
        RESP_SLVERR = 2'd2,
        RESP_DECERR = 2'd3
    } axi_resp_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } engine_state_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [15:0] addr;
        logic [7:0]  len;
        logic [1:0]  size;
        axi_burst_t  burst;
    } axi_ar_desc_t;

    // Response is decided once per burst; malformed requests take priority over decode misses.
    function automatic axi_resp_t ar_resp(input axi_ar_desc_t desc, input int unsigned depth_log2);
        logic wrap_len_ok;
        logic burst_ok;
        wrap_len_ok = (desc.len == 8'd1) || (desc.len == 8'd3) ||
                      (desc.len == 8'd7) || (desc.len == 8'd15);
        burst_ok    = (desc.burst == BURST_FIXED) || (desc.burst == BURST_INCR) ||
                      (desc.burst == BURST_WRAP);
        if ((desc.size != 2'd0) || !burst_ok || ((desc.burst == BURST_WRAP) && !wrap_len_ok)) begin
            return RESP_SLVERR;
        end
        if ((desc.addr >> depth_log2) != 16'd0) begin
            return RESP_DECERR;
        end
        return RESP_OKAY;
    endfunction

    // WRAP keeps the bits above the (len+1)-byte container and increments only inside it.
    function automatic logic [15:0] next_beat_addr(input logic [15:0] addr, input logic [7:0] len,
                                                   input axi_burst_t burst);
        logic [15:0] mask;
        mask = {8'h00, len};
        case (burst)
            BURST_INCR: return addr + 16'd1;
            BURST_WRAP: return (addr & ~mask) | ((addr + 16'd1) & mask);
            default:    return addr;
        endcase
    endfunction

endpackage

// File: rtl/axi_ar_queue.sv
// Two-entry synchronous FIFO of AR descriptors in front of the burst engine.
// Exposes full/empty plus the post-edge full flag so the owner can register a ready.
module axi_ar_queue
    import axi_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  axi_ar_desc_t push_desc_i,
    input  logic         pop_i,
    output axi_ar_desc_t head_o,
    output logic         full_o,
    output logic         empty_o,
    output logic         full_next_o
);

    axi_ar_desc_t slot_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;
    logic [1:0]   count_d;
    logic         do_push;
    logic         do_pop;

    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);
    assign head_o  = slot_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // NOTE: every variable written here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 2'd1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 2'd1;
        end
    end

    assign full_next_o = (count_d == 2'd2);

    // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            count_q <= count_d;
            if (do_push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    // NOTE: payload storage is not reset; count_q alone says which slots hold valid descriptors.
    always_ff @(posedge clk) begin
        if (do_push) begin
            slot_q[wr_ptr_q] <= push_desc_i;
        end
    end

endmodule

// File: rtl/axi_rd_mem_slave_addr16_data8_id4.sv
// AXI4 read-only byte memory slave: AR queue, one-beat-per-cycle burst engine and
// a read-first synchronous RAM whose read port feeds the R output register directly.
module axi_rd_mem_slave_addr16_data8_id4
    import axi_pkg::*;
#(
    parameter int DEPTH_LOG2 = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        axi_arvalid,
    output logic        axi_arready,
    input  logic [3:0]  axi_arid,
    input  logic [15:0] axi_araddr,
    input  logic [7:0]  axi_arlen,
    input  logic [1:0]  axi_arsize,
    input  logic [1:0]  axi_arburst,
    input  logic [1:0]  axi_arlock,
    input  logic [3:0]  axi_arcache,
    input  logic [2:0]  axi_arprot,
    input  logic [3:0]  axi_arqos,
    output logic        axi_rvalid,
    input  logic        axi_rready,
    output logic [3:0]  axi_rid,
    output logic [7:0]  axi_rdata,
    output logic [1:0]  axi_rresp,
    output logic        axi_rlast,
    input  logic        mem_wr_en,
    input  logic [15:0] mem_wr_addr,
    input  logic [7:0]  mem_wr_data
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

    logic unused_ar_attrs;
    assign unused_ar_attrs = ^{axi_arlock, axi_arcache, axi_arprot, axi_arqos};

    axi_ar_desc_t  ar_desc;
    axi_ar_desc_t  head;
    logic          ar_push;
    logic          q_pop;
    logic          q_full;
    logic          q_empty;
    logic          q_full_next;

    engine_state_t state_q, state_d;
    logic [15:0]   addr_q, addr_d;
    logic [7:0]    len_q, len_d;
    axi_burst_t    burst_q, burst_d;
    logic [7:0]    beat_q, beat_d;
    logic [3:0]    rid_q, rid_d;
    axi_resp_t     rresp_q, rresp_d;
    logic          rlast_q, rlast_d;
    logic          rvalid_q, rvalid_d;
    logic          arready_q;
    logic [7:0]    rdata_q;
    logic          rd_en;
    logic          r_hs;

    logic [7:0]    mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic          wr_in_range;

    assign ar_desc = '{id: axi_arid, addr: axi_araddr, len: axi_arlen, size: axi_arsize,
                       burst: axi_burst_t'(axi_arburst)};
    assign ar_push = axi_arvalid && arready_q;

    axi_ar_queue u_ar_queue (
        .clk         (clk),
        .reset       (reset),
        .push_i      (ar_push),
        .push_desc_i (ar_desc),
        .pop_i       (q_pop),
        .head_o      (head),
        .full_o      (q_full),
        .empty_o     (q_empty),
        .full_next_o (q_full_next)
    );

    assign r_hs = rvalid_q && axi_rready;

    // A new burst loads either from IDLE or straight off a last-beat handshake, giving zero bubble.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        len_d    = len_q;
        burst_d  = burst_q;
        beat_d   = beat_q;
        rid_d    = rid_q;
        rresp_d  = rresp_q;
        rlast_d  = rlast_q;
        rvalid_d = rvalid_q;
        q_pop    = 1'b0;
        rd_en    = 1'b0;
        if (((state_q == ST_IDLE) || (r_hs && rlast_q)) && !q_empty) begin
            state_d  = ST_STREAM;
            addr_d   = head.addr;
            len_d    = head.len;
            burst_d  = head.burst;
            beat_d   = 8'd0;
            rid_d    = head.id;
            rresp_d  = ar_resp(head, DEPTH_LOG2);
            rlast_d  = (head.len == 8'd0);
            rvalid_d = 1'b1;
            q_pop    = 1'b1;
            rd_en    = 1'b1;
        end else if (r_hs && !rlast_q) begin
            addr_d  = next_beat_addr(addr_q, len_q, burst_q);
            beat_d  = beat_q + 8'd1;
            rlast_d = (beat_d == len_q);
            rd_en   = 1'b1;
        end else if (r_hs && rlast_q) begin
            state_d  = ST_IDLE;
            rvalid_d = 1'b0;
            rlast_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            burst_q   <= BURST_FIXED;
            beat_q    <= '0;
            rid_q     <= '0;
            rresp_q   <= RESP_OKAY;
            rlast_q   <= 1'b0;
            rvalid_q  <= 1'b0;
            arready_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            burst_q   <= burst_d;
            beat_q    <= beat_d;
            rid_q     <= rid_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
            rvalid_q  <= rvalid_d;
            arready_q <= !q_full_next;
        end
    end

    assign rd_idx      = addr_d[DEPTH_LOG2-1:0];
    assign wr_in_range = ((mem_wr_addr >> DEPTH_LOG2) == 16'd0);

    always_ff @(posedge clk) begin
        if (mem_wr_en && wr_in_range) begin
            mem_q[mem_wr_addr[DEPTH_LOG2-1:0]] <= mem_wr_data;
        end
    end

    // Reading mem_q in the same edge as a write returns the pre-write byte (read-first).
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (rd_en) begin
            rdata_q <= (rresp_d == RESP_OKAY) ? mem_q[rd_idx] : 8'h00;
        end
    end

    assign axi_arready = arready_q;
    assign axi_rvalid  = rvalid_q;
    assign axi_rid     = rid_q;
    assign axi_rdata   = rdata_q;
    assign axi_rresp   = rresp_q;
    assign axi_rlast   = rlast_q;

endmodule

// File: tb/tb_axi_rd_mem_slave_addr16_data8_id4.sv
// Directed bench for the AXI read memory slave; a second instance with a 4 KiB RAM
// shares every input and is used only to observe decode errors.
module tb_axi_rd_mem_slave_addr16_data8_id4;

    logic        clk = 1'b0;
    logic        reset;
    logic        arvalid;
    logic [3:0]  arid;
    logic [15:0] araddr;
    logic [7:0]  arlen;
    logic [1:0]  arsize;
    logic [1:0]  arburst;
    logic        rready;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;

    logic        arready, rvalid, rlast;
    logic [3:0]  rid;
    logic [7:0]  rdata;
    logic [1:0]  rresp;
    logic        arready_b, rvalid_b, rlast_b;
    logic [3:0]  rid_b;
    logic [7:0]  rdata_b;
    logic [1:0]  rresp_b;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    axi_rd_mem_slave_addr16_data8_id4 #(.DEPTH_LOG2(16)) dut (
        .clk(clk), .reset(reset),
        .axi_arvalid(arvalid), .axi_arready(arready), .axi_arid(arid), .axi_araddr(araddr),
        .axi_arlen(arlen), .axi_arsize(arsize), .axi_arburst(arburst),
        .axi_arlock(2'b00), .axi_arcache(4'h0), .axi_arprot(3'b000), .axi_arqos(4'h0),
        .axi_rvalid(rvalid), .axi_rready(rready), .axi_rid(rid), .axi_rdata(rdata),
        .axi_rresp(rresp), .axi_rlast(rlast),
        .mem_wr_en(wr_en), .mem_wr_addr(wr_addr), .mem_wr_data(wr_data)
    );

    axi_rd_mem_slave_addr16_data8_id4 #(.DEPTH_LOG2(12)) dut12 (
        .clk(clk), .reset(reset),
        .axi_arvalid(arvalid), .axi_arready(arready_b), .axi_arid(arid), .axi_araddr(araddr),
        .axi_arlen(arlen), .axi_arsize(arsize), .axi_arburst(arburst),
        .axi_arlock(2'b00), .axi_arcache(4'h0), .axi_arprot(3'b000), .axi_arqos(4'h0),
        .axi_rvalid(rvalid_b), .axi_rready(rready), .axi_rid(rid_b), .axi_rdata(rdata_b),
        .axi_rresp(rresp_b), .axi_rlast(rlast_b),
        .mem_wr_en(wr_en), .mem_wr_addr(wr_addr), .mem_wr_data(wr_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_beat(input string tag, input logic [3:0] id, input logic [7:0] data,
                              input logic [1:0] resp, input logic last);
        check({tag, ".rvalid"}, 32'(rvalid), 32'd1);
        check({tag, ".rid"},    32'(rid),    32'(id));
        check({tag, ".rdata"},  32'(rdata),  32'(data));
        check({tag, ".rresp"},  32'(rresp),  32'(resp));
        check({tag, ".rlast"},  32'(rlast),  32'(last));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mem_write(input logic [15:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    // Returns just after the edge on which the AR handshake took place.
    task automatic ar_send(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
                           input logic [1:0] size, input logic [1:0] burst);
        logic hs;
        int   waited;
        arvalid = 1'b1;
        arid    = id;
        araddr  = addr;
        arlen   = len;
        arsize  = size;
        arburst = burst;
        hs      = 1'b0;
        waited  = 0;
        while (!hs && waited < 50) begin
            hs = arready;
            tick();
            waited++;
        end
        arvalid = 1'b0;
        check("ar_handshake", 32'(hs), 32'd1);
    endtask

    initial begin
        reset   = 1'b1;
        arvalid = 1'b0;
        arid    = '0;
        araddr  = '0;
        arlen   = '0;
        arsize  = '0;
        arburst = '0;
        rready  = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        repeat (3) tick();

        check("rst.arready", 32'(arready), 32'd0);
        check("rst.rvalid",  32'(rvalid),  32'd0);
        check("rst.rlast",   32'(rlast),   32'd0);
        check("rst.rid",     32'(rid),     32'd0);
        check("rst.rdata",   32'(rdata),   32'd0);
        check("rst.rresp",   32'(rresp),   32'd0);

        reset = 1'b0;
        check("rst.arready_before_edge", 32'(arready), 32'd0);
        tick();
        check("rst.arready_rise", 32'(arready), 32'd1);

        for (int i = 0; i < 64; i++) mem_write(16'(i), 8'(i));
        mem_write(16'h0010, 8'h5A);
        mem_write(16'h0020, 8'hC3);
        mem_write(16'hFFFE, 8'hFE);
        mem_write(16'hFFFF, 8'hFF);

        // Single-beat read: first beat after E0+1.
        rready = 1'b1;
        ar_send(4'd3, 16'h0010, 8'd0, 2'd0, 2'd1);
        check("single.not_early", 32'(rvalid), 32'd0);
        tick();
        check_beat("single.b0", 4'd3, 8'h5A, 2'd0, 1'b1);
        tick();
        check("single.done", 32'(rvalid), 32'd0);

        // INCR across the 16-bit wrap with back-pressure and a write during a stall.
        ar_send(4'd5, 16'hFFFE, 8'd3, 2'd0, 2'd1);
        rready = 1'b0;
        tick();
        check_beat("incr.b0", 4'd5, 8'hFE, 2'd0, 1'b0);
        wr_en = 1'b1; wr_addr = 16'hFFFE; wr_data = 8'h11;
        tick();
        wr_en = 1'b0;
        check_beat("incr.b0_stall", 4'd5, 8'hFE, 2'd0, 1'b0);
        rready = 1'b1;
        tick();
        check_beat("incr.b1", 4'd5, 8'hFF, 2'd0, 1'b0);
        rready = 1'b0;
        tick();
        check_beat("incr.b1_stall1", 4'd5, 8'hFF, 2'd0, 1'b0);
        tick();
        check_beat("incr.b1_stall2", 4'd5, 8'hFF, 2'd0, 1'b0);
        rready = 1'b1;
        tick();
        check_beat("incr.b2", 4'd5, 8'h00, 2'd0, 1'b0);
        tick();
        check_beat("incr.b3", 4'd5, 8'h01, 2'd0, 1'b1);
        rready = 1'b0;
        tick();
        check_beat("incr.b3_stall", 4'd5, 8'h01, 2'd0, 1'b1);
        rready = 1'b1;
        tick();
        check("incr.done", 32'(rvalid), 32'd0);

        // WRAP 6,7,4,5 with a same-edge write on the beat reading address 4.
        ar_send(4'd6, 16'h0006, 8'd3, 2'd0, 2'd2);
        tick();
        check_beat("wrap.b0", 4'd6, 8'h06, 2'd0, 1'b0);
        tick();
        check_beat("wrap.b1", 4'd6, 8'h07, 2'd0, 1'b0);
        wr_en = 1'b1; wr_addr = 16'h0004; wr_data = 8'h99;
        tick();
        wr_en = 1'b0;
        check_beat("wrap.b2_read_first", 4'd6, 8'h04, 2'd0, 1'b0);
        tick();
        check_beat("wrap.b3", 4'd6, 8'h05, 2'd0, 1'b1);
        tick();
        check("wrap.done", 32'(rvalid), 32'd0);

        // FIXED: three beats of the same byte.
        ar_send(4'd7, 16'h0020, 8'd2, 2'd0, 2'd0);
        tick();
        check_beat("fixed.b0", 4'd7, 8'hC3, 2'd0, 1'b0);
        tick();
        check_beat("fixed.b1", 4'd7, 8'hC3, 2'd0, 1'b0);
        tick();
        check_beat("fixed.b2", 4'd7, 8'hC3, 2'd0, 1'b1);
        tick();
        check("fixed.done", 32'(rvalid), 32'd0);

        // Error bursts keep their beat count and return zero data.
        ar_send(4'd10, 16'h0010, 8'd1, 2'd1, 2'd1);
        tick();
        check_beat("err_size.b0", 4'd10, 8'h00, 2'd2, 1'b0);
        tick();
        check_beat("err_size.b1", 4'd10, 8'h00, 2'd2, 1'b1);
        tick();
        check("err_size.done", 32'(rvalid), 32'd0);

        ar_send(4'd11, 16'h0010, 8'd0, 2'd0, 2'd3);
        tick();
        check_beat("err_burst3.b0", 4'd11, 8'h00, 2'd2, 1'b1);
        tick();

        ar_send(4'd12, 16'h0010, 8'd2, 2'd0, 2'd2);
        tick();
        check_beat("err_wraplen.b0", 4'd12, 8'h00, 2'd2, 1'b0);
        tick();
        tick();
        check_beat("err_wraplen.b2", 4'd12, 8'h00, 2'd2, 1'b1);
        tick();

        ar_send(4'd13, 16'h1000, 8'd0, 2'd0, 2'd1);
        tick();
        check("decerr.rvalid_b", 32'(rvalid_b), 32'd1);
        check("decerr.rresp_b",  32'(rresp_b),  32'd3);
        check("decerr.rdata_b",  32'(rdata_b),  32'd0);
        check("decerr.rlast_b",  32'(rlast_b),  32'd1);
        check("decerr.rid_b",    32'(rid_b),    32'd13);
        check("decerr.rresp_full_depth", 32'(rresp), 32'd0);
        tick();
        check("decerr.done", 32'(rvalid), 32'd0);

        // Queue full: the first burst is taken by the engine, the next two fill the queue.
        rready = 1'b0;
        ar_send(4'd1, 16'h0030, 8'd1, 2'd0, 2'd1);
        ar_send(4'd2, 16'h0034, 8'd0, 2'd0, 2'd1);
        check("qfull.arready_after_2", 32'(arready), 32'd1);
        ar_send(4'd4, 16'h0038, 8'd2, 2'd0, 2'd1);
        check("qfull.arready_low", 32'(arready), 32'd0);
        check_beat("qfull.a0", 4'd1, 8'h30, 2'd0, 1'b0);
        tick();
        check("qfull.arready_still_low", 32'(arready), 32'd0);
        check_beat("qfull.a0_stall", 4'd1, 8'h30, 2'd0, 1'b0);
        rready = 1'b1;
        tick();
        check_beat("qfull.a1", 4'd1, 8'h31, 2'd0, 1'b1);
        check("qfull.arready_a1", 32'(arready), 32'd0);
        tick();
        check_beat("qfull.b0", 4'd2, 8'h34, 2'd0, 1'b1);
        check("qfull.arready_after_pop", 32'(arready), 32'd1);
        tick();
        check_beat("qfull.c0", 4'd4, 8'h38, 2'd0, 1'b0);
        tick();
        check_beat("qfull.c1", 4'd4, 8'h39, 2'd0, 1'b0);
        tick();
        check_beat("qfull.c2", 4'd4, 8'h3A, 2'd0, 1'b1);
        tick();
        check("qfull.done", 32'(rvalid), 32'd0);

        // Reset during beat 2 of a len=7 burst with another descriptor queued.
        rready = 1'b0;
        ar_send(4'd7, 16'h0030, 8'd7, 2'd0, 2'd1);
        ar_send(4'd8, 16'h0020, 8'd0, 2'd0, 2'd1);
        rready = 1'b1;
        tick();
        check_beat("rstmid.b1", 4'd7, 8'h31, 2'd0, 1'b0);
        tick();
        check_beat("rstmid.b2", 4'd7, 8'h32, 2'd0, 1'b0);
        reset = 1'b1;
        tick();
        check("rstmid.rvalid",  32'(rvalid),  32'd0);
        check("rstmid.rlast",   32'(rlast),   32'd0);
        check("rstmid.rid",     32'(rid),     32'd0);
        check("rstmid.rdata",   32'(rdata),   32'd0);
        check("rstmid.rresp",   32'(rresp),   32'd0);
        check("rstmid.arready", 32'(arready), 32'd0);
        reset = 1'b0;
        tick();
        check("rstmid.no_beat1", 32'(rvalid),  32'd0);
        check("rstmid.arready_back", 32'(arready), 32'd1);
        tick();
        check("rstmid.no_beat2", 32'(rvalid), 32'd0);
        ar_send(4'd9, 16'h0010, 8'd0, 2'd0, 2'd1);
        tick();
        check_beat("rstmid.fresh", 4'd9, 8'h5A, 2'd0, 1'b1);
        tick();
        check("rstmid.fresh_done", 32'(rvalid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
